// File: rtl/bin2bcd_seq_if.sv
// Register-tap to display bus: 32-bit binary value in, packed BCD digits plus status out.
`timescale 1ns/1ps
interface bin2bcd_seq_if;
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] i_data;
    logic              i_start;
    logic [DATA_W-1:0] o_bcd;
    logic              o_ovf;
    logic              o_busy;
    logic              o_valid;

    modport master (
        output i_data, i_start,
        input  o_bcd, o_ovf, o_busy, o_valid
    );

    modport slave (
        input  i_data, i_start,
        output o_bcd, o_ovf, o_busy, o_valid
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (shift-add-3, one bit per clock).
// Ten digits are built internally; the top two only feed the overflow flag.
`timescale 1ns/1ps
module bin2bcd_seq #(
    parameter bit          AUTO  = 1'b1,
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int unsigned DIGITS = 10;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [WIDTH-1:0]     last_q, last_d;
    logic [BCD_W-1:0]     bcd_sr_q, bcd_sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;

    logic                 trigger_c;
    logic                 last_iter_c;
    logic [BCD_W-1:0]     adj_c;

    // Pre-shift correction: any digit >= 5 would exceed 9 after doubling.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign trigger_c   = (state_q == IDLE) &&
                         (bus.i_start || (AUTO && (bus.i_data != last_q)));
    assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));
    assign adj_c       = add3(bcd_sr_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger_c) state_d = SHIFT;
            SHIFT:   if (last_iter_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        bin_d    = bin_q;
        last_d   = last_q;
        bcd_sr_d = bcd_sr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger_c) begin
                    bin_d    = bus.i_data;
                    last_d   = bus.i_data;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            SHIFT: begin
                {bcd_sr_d, bin_d} = {adj_c, bin_q} << 1;
                cnt_d             = cnt_q + CNT_W'(1);
            end
            DONE: begin
                bcd_d   = bcd_sr_q[OUT_W-1:0];
                ovf_d   = |bcd_sr_q[BCD_W-1:OUT_W];
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            last_q   <= '0;
            bcd_sr_q <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            last_q   <= last_d;
            bcd_sr_q <= bcd_sr_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_bcd   = bcd_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and reference-model bench for bin2bcd_seq; one manual-start and one auto-trigger instance.
`timescale 1ns/1ps
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if m_if ();
    bin2bcd_seq_if a_if ();

    bin2bcd_seq #(.AUTO(1'b0), .WIDTH(32)) u_man  (.clk(clk), .rst(rst), .bus(m_if));
    bin2bcd_seq #(.AUTO(1'b1), .WIDTH(32)) u_auto (.clk(clk), .rst(rst), .bus(a_if));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic nibbles_ok(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic void model(input logic [31:0] v, output logic [31:0] b, output logic o);
        longint unsigned x;
        x = longint'(v);
        o = (x >= 64'd100000000);
        x = x % 64'd100000000;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(x % 64'd10);
            x = x / 64'd10;
        end
    endfunction

    // Returns the negedge index (1-based) at which o_valid is seen, or -1 on timeout.
    task automatic wait_valid(input bit use_auto, input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (use_auto ? a_if.o_valid : m_if.o_valid) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run_man(input logic [31:0] val, input logic [31:0] exp_bcd, input logic exp_ovf);
        int k;
        @(negedge clk);
        m_if.i_data  = val;
        m_if.i_start = 1'b1;
        @(negedge clk);
        m_if.i_start = 1'b0;
        check("busy_on_start", 32'(m_if.o_busy), 32'd1);
        wait_valid(1'b0, 40, k);
        check("latency", 32'(k), 32'd33);
        check("bcd", m_if.o_bcd, exp_bcd);
        check("ovf", 32'(m_if.o_ovf), 32'(exp_ovf));
        check("busy_off_done", 32'(m_if.o_busy), 32'd0);
        @(negedge clk);
        check("valid_one_cycle", 32'(m_if.o_valid), 32'd0);
    endtask

    initial begin
        int          k;
        int          k2;
        int          pulses;
        int          first_k;
        int          second_k;
        logic        saw_busy;
        logic [31:0] val;
        logic [31:0] exp_b;
        logic        exp_o;

        m_if.i_data  = '0;
        m_if.i_start = 1'b0;
        a_if.i_data  = '0;
        a_if.i_start = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bcd", m_if.o_bcd, 32'd0);
        check("rst_ovf", 32'(m_if.o_ovf), 32'd0);
        check("rst_busy", 32'(m_if.o_busy), 32'd0);
        check("rst_valid", 32'(m_if.o_valid), 32'd0);
        rst = 1'b0;

        // Auto mode with i_data=0 after reset stays idle
        saw_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_if.o_busy || a_if.o_valid) saw_busy = 1'b1;
        end
        check("auto_zero_idle", 32'(saw_busy), 32'd0);

        // Directed conversions
        run_man(32'h00BC614E, 32'h12345678, 1'b0);
        run_man(32'h05F5E0FF, 32'h99999999, 1'b0);
        run_man(32'h05F5E100, 32'h00000000, 1'b1);
        run_man(32'hFFFFFFFF, 32'h94967295, 1'b1);
        run_man(32'h00000000, 32'h00000000, 1'b0);

        // Held start: one conversion every 34 cycles
        @(negedge clk);
        m_if.i_data  = 32'd5;
        m_if.i_start = 1'b1;
        pulses   = 0;
        first_k  = -1;
        second_k = -1;
        @(negedge clk);
        for (int i = 1; i <= 101; i++) begin
            @(negedge clk);
            if (m_if.o_valid) begin
                pulses++;
                if (first_k < 0) first_k = i;
                else if (second_k < 0) second_k = i;
            end
        end
        m_if.i_start = 1'b0;
        check("held_pulses", 32'(pulses), 32'd3);
        check("held_first", 32'(first_k), 32'd33);
        check("held_spacing", 32'(second_k - first_k), 32'd34);
        check("held_bcd", m_if.o_bcd, 32'h00000005);
        repeat (40) @(negedge clk);

        // Start and data change during busy are ignored in manual mode
        m_if.i_data  = 32'd42;
        m_if.i_start = 1'b1;
        @(negedge clk);
        m_if.i_start = 1'b0;
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5)  m_if.i_start = 1'b1;
            if (i == 6)  m_if.i_start = 1'b0;
            if (i == 10) m_if.i_data  = 32'd7;
            if (m_if.o_valid) begin
                k = i;
                break;
            end
        end
        check("busy_chg_latency", 32'(k), 32'd33);
        check("busy_chg_bcd", m_if.o_bcd, 32'h00000042);
        saw_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_if.o_busy) saw_busy = 1'b1;
        end
        check("no_queue", 32'(saw_busy), 32'd0);

        // Auto mode: change to 7 mid-conversion retriggers in the first idle cycle
        a_if.i_data = 32'd42;
        @(negedge clk);
        check("auto_busy", 32'(a_if.o_busy), 32'd1);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 10) a_if.i_data = 32'd7;
            if (a_if.o_valid) begin
                k = i;
                break;
            end
        end
        check("auto_latency", 32'(k), 32'd33);
        check("auto_bcd1", a_if.o_bcd, 32'h00000042);
        wait_valid(1'b1, 40, k2);
        check("auto_retrig", 32'(k2), 32'd34);
        check("auto_bcd2", a_if.o_bcd, 32'h00000007);
        saw_busy = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (a_if.o_busy) saw_busy = 1'b1;
        end
        check("auto_stable", 32'(saw_busy), 32'd0);

        // Reset mid-conversion
        a_if.i_data = 32'h00012345;
        repeat (16) @(negedge clk);
        check("pre_rst_busy", 32'(a_if.o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_busy", 32'(a_if.o_busy), 32'd0);
        check("async_bcd", a_if.o_bcd, 32'd0);
        check("async_valid", 32'(a_if.o_valid), 32'd0);
        check("async_man_bcd", m_if.o_bcd, 32'd0);
        a_if.i_data = 32'h00000064;
        @(negedge clk);
        check("rst_held_valid", 32'(a_if.o_valid), 32'd0);
        rst = 1'b0;
        wait_valid(1'b1, 40, k);
        check("post_rst_latency", 32'(k), 32'd34);
        check("post_rst_bcd", a_if.o_bcd, 32'h00000100);
        check("post_rst_ovf", 32'(a_if.o_ovf), 32'd0);

        // Reference-model sweep
        for (int n = 0; n < 1000; n++) begin
            val = (n % 2 == 0) ? $urandom : ($urandom % 32'd100000000);
            model(val, exp_b, exp_o);
            @(negedge clk);
            m_if.i_data  = val;
            m_if.i_start = 1'b1;
            @(negedge clk);
            m_if.i_start = 1'b0;
            wait_valid(1'b0, 40, k);
            check("sweep_timeout", 32'(k > 0), 32'd1);
            check("sweep_bcd", m_if.o_bcd, exp_b);
            check("sweep_ovf", 32'(m_if.o_ovf), 32'(exp_o));
            check("sweep_nibbles", 32'(nibbles_ok(m_if.o_bcd)), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
